// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: turns the core's instruction-fetch and data SRAM-like
// ports into one AXI master. The read FSM arbitrates between the two ports.
// The data port uses the write FSM for stores. A data read must not overtake
// a store that is still in flight.
// Optional feature macro: BRIDGE_RAW_CHECK_EN. When it is defined, a data
// read is held back only if it hits the word of the pending store.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port (read-only)
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // data port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

    // Read path state
    r_state_e    r_state_q, r_state_d;
    logic        r_grant_data_q, r_grant_data_d;   // 1: data port owns the read
    logic [31:0] r_addr_q, r_addr_d;
    logic [1:0]  r_size_q, r_size_d;
    logic        r_addr_ok, r_data_ok;

    // Write path state
    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [1:0]  w_size_q, w_size_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic [31:0] w_data_q, w_data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        w_addr_ok, w_data_ok;
    logic        aw_hs, w_hs;

    logic        data_rd_req;
    logic        data_rd_blocked;

    // Write-only fetch fields and response ids/codes carry nothing we route on.
    logic        unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rid, rresp, rlast, bid, bresp};

    assign data_rd_req = data_sram_req & ~data_sram_wr;

`ifdef BRIDGE_RAW_CHECK_EN
    // Only a read of the same word as the in-flight store must wait for it.
    assign data_rd_blocked = (w_state_q != W_IDLE) &&
                             (data_sram_addr[31:2] == w_addr_q[31:2]);
`else
    // Any data read waits until the in-flight store has its response.
    assign data_rd_blocked = (w_state_q != W_IDLE);
`endif

    // Read FSM next state, latching and AR/R channel outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
        r_state_d      = r_state_q;
        r_grant_data_d = r_grant_data_q;
        r_addr_d       = r_addr_q;
        r_size_d       = r_size_q;
        arvalid        = 1'b0;
        rready         = 1'b0;
        r_addr_ok      = 1'b0;
        r_data_ok      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_req && !data_rd_blocked) begin
                    r_grant_data_d = 1'b1;
                    r_addr_d       = data_sram_addr;
                    r_size_d       = data_sram_size;
                    r_state_d      = R_AR;
                end else if (inst_sram_req) begin
                    r_grant_data_d = 1'b0;
                    r_addr_d       = inst_sram_addr;
                    r_size_d       = inst_sram_size;
                    r_state_d      = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_addr_ok = 1'b1;
                    r_state_d = R_R;
                end
            end
            R_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    r_data_ok = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state_q      <= R_IDLE;
            r_grant_data_q <= 1'b0;
            r_addr_q       <= '0;
            r_size_q       <= '0;
        end else begin
            r_state_q      <= r_state_d;
            r_grant_data_q <= r_grant_data_d;
            r_addr_q       <= r_addr_d;
            r_size_q       <= r_size_d;
        end
    end

    // AW and W each drop independently once their own handshake completes.
    assign awvalid = (w_state_q == W_REQ) && !aw_done_q;
    assign wvalid  = (w_state_q == W_REQ) && !w_done_q;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    // Write FSM next state, latching and handshake tracking.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_strb_d  = w_strb_q;
        w_data_d  = w_data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready    = 1'b0;
        w_addr_ok = 1'b0;
        w_data_ok = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (data_sram_req && data_sram_wr) begin
                    w_addr_d  = data_sram_addr;
                    w_size_d  = data_sram_size;
                    w_strb_d  = data_sram_wstrb;
                    w_data_d  = data_sram_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    w_addr_ok = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_B;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_data_ok = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: latched request fields are reset too, so the AXI address and data outputs read as zero after reset.
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_strb_q  <= '0;
            w_data_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_strb_q  <= w_strb_d;
            w_data_q  <= w_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Route the handshakes back to the granted port using the latched grant.
    assign inst_sram_addr_ok = r_addr_ok & ~r_grant_data_q;
    assign inst_sram_data_ok = r_data_ok & ~r_grant_data_q;
    assign inst_sram_rdata   = (r_data_ok && !r_grant_data_q) ? rdata : '0;
    assign data_sram_addr_ok = (r_addr_ok & r_grant_data_q) | w_addr_ok;
    assign data_sram_data_ok = (r_data_ok & r_grant_data_q) | w_data_ok;
    assign data_sram_rdata   = (r_data_ok && r_grant_data_q) ? rdata : '0;

    assign arid    = {3'b000, r_grant_data_q};
    assign araddr  = r_addr_q;
    assign arsize  = {1'b0, r_size_q};
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = 4'd1;
    assign awaddr  = w_addr_q;
    assign awsize  = {1'b0, w_size_q};
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = 4'd1;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: single reads, arbitration, split
// write handshakes, read-after-write blocking, and reset in mid-read.
module tb_sram_axi_bridge;

`ifdef BRIDGE_RAW_CHECK_EN
    localparam logic RAW_EN = 1'b1;
`else
    localparam logic RAW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete a read whose request is already presented: wait (bounded)
    // for AR, handshake it, then return one beat of data.
    task automatic read_tail(input string tag, input logic is_data,
                             input logic [31:0] addr, input logic [31:0] rd);
        int n = 0;
        while (arvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, " arvalid"}, {31'd0, arvalid}, 32'd1);
        chk({tag, " araddr"}, araddr, addr);
        chk({tag, " arid"}, {28'd0, arid}, {31'd0, is_data});
        arready = 1'b1;
        #1;
        chk({tag, " inst_addr_ok"}, {31'd0, inst_sram_addr_ok}, {31'd0, ~is_data});
        chk({tag, " data_addr_ok"}, {31'd0, data_sram_addr_ok}, {31'd0, is_data});
        tick();
        arready = 1'b0;
        if (is_data) data_sram_req = 1'b0;
        else         inst_sram_req = 1'b0;
        rvalid = 1'b1;
        rdata  = rd;
        #1;
        chk({tag, " rready"}, {31'd0, rready}, 32'd1);
        chk({tag, " arvalid in R"}, {31'd0, arvalid}, 32'd0);
        chk({tag, " inst_data_ok"}, {31'd0, inst_sram_data_ok}, {31'd0, ~is_data});
        chk({tag, " data_data_ok"}, {31'd0, data_sram_data_ok}, {31'd0, is_data});
        chk({tag, " rdata"}, is_data ? data_sram_rdata : inst_sram_rdata, rd);
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
        inst_sram_addr = '0; inst_sram_wstrb = '0; inst_sram_wdata = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
        data_sram_addr = '0; data_sram_wstrb = '0; data_sram_wdata = '0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
        #2;

        // ---- reset state ----
        chk("rst arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst wvalid", {31'd0, wvalid}, 32'd0);
        chk("rst rready", {31'd0, rready}, 32'd0);
        chk("rst bready", {31'd0, bready}, 32'd0);
        chk("rst araddr", araddr, 32'd0);
        chk("rst inst_rdata", inst_sram_rdata, 32'd0);
        chk("rst oks", {28'd0, inst_sram_addr_ok, inst_sram_data_ok,
                        data_sram_addr_ok, data_sram_data_ok}, 32'd0);
        chk("rst constants", {awid, wid, 23'd0, wlast}, {4'd1, 4'd1, 23'd0, 1'b1});
        tick();
        reset = 1'b0;
        tick();

        // ---- inst read 0x1c000000, arready immediate, rvalid 2 cycles later ----
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000;
        #1;
        chk("i1 c0 arvalid", {31'd0, arvalid}, 32'd0);
        tick();
        arready = 1'b1;
        #1;
        chk("i1 c1 arvalid", {31'd0, arvalid}, 32'd1);
        chk("i1 c1 araddr", araddr, 32'h1c00_0000);
        chk("i1 c1 arid", {28'd0, arid}, 32'd0);
        chk("i1 c1 arsize", {29'd0, arsize}, 32'd2);
        chk("i1 c1 inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        chk("i1 c1 data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd0);
        tick();
        inst_sram_req = 1'b0; arready = 1'b0;
        #1;
        chk("i1 c2 rready", {31'd0, rready}, 32'd1);
        chk("i1 c2 inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        tick();
        rvalid = 1'b1; rdata = 32'h0280_0000;
        #1;
        chk("i1 c3 inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        chk("i1 c3 inst_rdata", inst_sram_rdata, 32'h0280_0000);
        chk("i1 c3 data_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        tick();
        rvalid = 1'b0; rdata = '0;
        #1;
        chk("i1 c4 rready", {31'd0, rready}, 32'd0);
        chk("i1 c4 inst_rdata", inst_sram_rdata, 32'd0);

        // ---- inst and data read together: data first ----
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0004;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0080;
        #1;
        chk("prio c0 arvalid", {31'd0, arvalid}, 32'd0);
        read_tail("prio data", 1'b1, 32'h0000_0080, 32'h1111_2222);
        chk("prio gap arvalid", {31'd0, arvalid}, 32'd0);
        read_tail("prio inst", 1'b0, 32'h1c00_0004, 32'h3333_4444);

        // ---- write 0x100: awready at c1, wready at c3 ----
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0100;
        data_sram_wstrb = 4'hf; data_sram_wdata = 32'hdead_beef;
        #1;
        chk("wr c0 awvalid", {31'd0, awvalid}, 32'd0);
        tick();
        awready = 1'b1;
        #1;
        chk("wr c1 aw/w valid", {30'd0, awvalid, wvalid}, 32'd3);
        chk("wr c1 awaddr", awaddr, 32'h0000_0100);
        chk("wr c1 wdata", wdata, 32'hdead_beef);
        chk("wr c1 wstrb", {28'd0, wstrb}, 32'hf);
        chk("wr c1 addr_ok", {31'd0, data_sram_addr_ok}, 32'd0);
        tick();
        awready = 1'b0;
        #1;
        chk("wr c2 aw/w valid", {30'd0, awvalid, wvalid}, 32'd1);
        chk("wr c2 addr_ok", {31'd0, data_sram_addr_ok}, 32'd0);
        tick();
        wready = 1'b1;
        #1;
        chk("wr c3 wvalid", {31'd0, wvalid}, 32'd1);
        chk("wr c3 addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        tick();
        wready = 1'b0; data_sram_req = 1'b0; data_sram_wr = 1'b0;
        #1;
        chk("wr c4 bready", {31'd0, bready}, 32'd1);
        chk("wr c4 aw/w valid", {30'd0, awvalid, wvalid}, 32'd0);
        chk("wr c4 data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        tick();
        bvalid = 1'b1;
        #1;
        chk("wr c5 data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        chk("wr c5 inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("wr c6 bready", {31'd0, bready}, 32'd0);

        // ---- pending write to 0x100: same-word read waits, inst read goes ----
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0100;
        data_sram_wdata = 32'h0bad_f00d;
        tick();
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("raw c1 addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        tick();
        awready = 1'b0; wready = 1'b0;
        data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0100;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0008;
        #1;
        chk("raw c2 bready", {31'd0, bready}, 32'd1);
        read_tail("raw inst", 1'b0, 32'h1c00_0008, 32'h4444_5555);
        chk("raw hold1 arvalid", {31'd0, arvalid}, 32'd0);
        tick();
        chk("raw hold2 arvalid", {31'd0, arvalid}, 32'd0);
        bvalid = 1'b1;
        #1;
        chk("raw bvalid data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        tick();
        bvalid = 1'b0;
        #1;
        chk("raw post-b arvalid", {31'd0, arvalid}, 32'd0);
        read_tail("raw data", 1'b1, 32'h0000_0100, 32'h5555_6666);

        // ---- pending write to 0x100, read of 0x200 ----
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0100;
        tick();
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("far c1 addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        tick();
        awready = 1'b0; wready = 1'b0;
        data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0200;
        #1;
        chk("far c2 arvalid", {31'd0, arvalid}, 32'd0);
        tick();
        chk("far c3 arvalid", {31'd0, arvalid}, {31'd0, RAW_EN});
        bvalid = 1'b1;
        #1;
        chk("far c3 data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        tick();
        bvalid = 1'b0;
        #1;
        read_tail("far data", 1'b1, 32'h0000_0200, 32'h6666_7777);

        // ---- reset while in R_R ----
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_000c;
        tick();
        arready = 1'b1;
        #1;
        chk("rr c1 inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        arready = 1'b0; inst_sram_req = 1'b0;
        #1;
        chk("rr c2 rready", {31'd0, rready}, 32'd1);
        #1;
        reset = 1'b1;
        rvalid = 1'b1; rdata = 32'h7777_8888;
        #1;
        chk("rr rst valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rr rst inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("rr rst inst_rdata", inst_sram_rdata, 32'd0);
        tick();
        reset = 1'b0; rvalid = 1'b0; rdata = '0;
        #1;
        chk("rr after rready", {31'd0, rready}, 32'd0);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0010;
        read_tail("post rst", 1'b0, 32'h1c00_0010, 32'h8888_9999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
